cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Arbitrates completed results from the execution units fed by the dispatcher (add/sub, mul, div, log, rot, cmp, sys, trap) onto the single common data bus (CDB). Uses round-robin priority and a one-entry registered output stage. The CDB is the broadcast path to reservation stations and the register file. Each broadcast is tagged with the reservation-station ID the dispatcher allocated to the instruction.

## Interface
Parameters:
- NUM_UNITS, 8, number of requesting execution units; index order matches dispatcher port order (0 = add_sub … 7 = trap)
- RS_ID_WIDTH, 5, width of the reservation-station tag
- DATA_WIDTH, 32, result width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- unit_valid  in  NUM_UNITS  per-unit result valid
- unit_ready  out  NUM_UNITS  per-unit accept; a transfer occurs when unit_valid[i] && unit_ready[i]
- unit_result  in  NUM_UNITS × cdb_result_t  per-unit {rs_id, result, so, cr_en, cr}
- cdb_valid  out  1  CDB holds a valid broadcast
- cdb_ready  in  1  downstream consumer accepts the broadcast
- cdb_result  out  cdb_result_t  broadcast payload
- cdb_grant_id  out  $clog2(NUM_UNITS)  index of the unit that produced the current broadcast

## Operation
- State:
  - output register {cdb_valid, cdb_result, cdb_grant_id}
  - round-robin pointer rr_ptr, $clog2(NUM_UNITS) bits
- Reset values (cycle after rst sampled high): cdb_valid=0, cdb_result=all zeros, cdb_grant_id=0, rr_ptr=0.
- unit_ready is all zeros while rst is high.
- can_load = !cdb_valid || cdb_ready.
- Arbitration (combinational):
  - Search unit_valid starting at index rr_ptr, wrapping modulo NUM_UNITS.
  - The first set index is the winner w.
  - If no unit is valid, there is no grant.
- unit_ready = one-hot(w) when can_load && a winner exists; otherwise zero.
  - At most one bit of unit_ready is set in any cycle.
- On a transfer from w:
  - Output register loads {1, unit_result[w], w}.
  - rr_ptr <= (w + 1) mod NUM_UNITS; wraps from NUM_UNITS-1 to 0.
- When cdb_ready && cdb_valid and there is no new transfer: cdb_valid <= 0. Payload is held; its value is don't-care.
- When cdb_valid && !cdb_ready: the output register and rr_ptr hold, and all unit_ready are 0 (full stall).
- rr_ptr changes only on a transfer.
- Fairness: a continuously valid unit is granted within NUM_UNITS transfers.
- Unit protocol:
  - unit_valid must not depend on unit_ready.
  - Once asserted, unit_valid and unit_result stay stable until accepted.
  - The arbiter never drops or duplicates a result.
- Reset mid-operation:
  - Any pending broadcast is discarded (cdb_valid=0).
  - Units are not acknowledged in the reset cycle and must be flushed by their own reset.

## Timing
- Latency: 1 cycle from unit handshake to cdb_valid.
- Throughput: one broadcast per cycle while cdb_ready=1 (back-to-back loads via the can_load path).
- cdb_ready → unit_ready is a combinational path, and so is unit_valid → unit_ready.
- No combinational path from any input to cdb_valid or cdb_result.
- Simultaneous drain and load: a new transfer overwrites the register in the same edge that the old broadcast is consumed, so cdb_valid stays 1.

## Structure
- Shared package ppc_types:
  - cdb_result_t, a packed struct: rs_id[RS_ID_WIDTH], result[DATA_WIDTH], so, cr_en, cr[3:0]
  - constant NUM_EXEC_UNITS = 8
  - enum exec_unit_e naming the eight unit indices
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; reused later for the dispatcher's reservation-station allocation.
- cdb_arbiter holds the output register and rr_ptr.

## Test plan
- Reset: assert rst 2 cycles with all unit_valid=1 → unit_ready=0 during reset; afterwards cdb_valid=0, rr_ptr=0, first grant goes to unit 0.
- Single requester: unit 3 valid with rs_id=5'd17, result=32'hDEADBEEF, cdb_ready=1 → unit_ready=8'b0000_1000 that cycle; next cycle cdb_valid=1, rs_id=17, result=DEADBEEF, cdb_grant_id=3.
- Round-robin wrap: all 8 units continuously valid, cdb_ready=1 → grant sequence 0,1,…,7,0 with one broadcast per cycle and no gaps.
- Pointer skip: rr_ptr=6 with units 1 and 4 valid → unit 1 granted first (wrap past 7), then unit 4.
- Backpressure: cdb_ready=0 for 3 cycles with units 2 and 5 valid → cdb_result stable, unit_ready=0 for all 3 cycles, rr_ptr unchanged; on release, one transfer per cycle, no loss or duplication.
- Reset mid-stall: cdb_valid=1, cdb_ready=0, then rst for 1 cycle → cdb_valid=0, rr_ptr=0 afterwards, and the stalled result is never broadcast.

Source files
------------

// File: rtl/ppc_types.sv
// Shared types for the execution back end: CDB payload, unit count and unit index names.
// Pure declarations; no logic, no latency, no flow control.
package ppc_types;

    localparam int NUM_EXEC_UNITS = 8;
    localparam int RS_ID_W        = 5;
    localparam int DATA_W         = 32;

    // Index order matches the dispatcher's port order.
    typedef enum logic [2:0] {
        EU_ADD_SUB = 3'd0,
        EU_MUL     = 3'd1,
        EU_DIV     = 3'd2,
        EU_LOG     = 3'd3,
        EU_ROT     = 3'd4,
        EU_CMP     = 3'd5,
        EU_SYS     = 3'd6,
        EU_TRAP    = 3'd7
    } exec_unit_e;

    typedef struct packed {
        logic [RS_ID_W-1:0] rs_id;
        logic [DATA_W-1:0]  result;
        logic               so;
        logic               cr_en;
        logic [3:0]         cr;
    } cdb_result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first set req bit at or after ptr, wrapping.
// Purely combinational, zero latency.
// No backpressure of its own; en low forces the one-hot grant to zero (index still reported).
module rr_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic found;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [IDX_W-1:0] j;
            j = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt_idx = j;
            end
        end
        if (found && en) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter of execution-unit results onto the single common data bus.
// Latency: 1 cycle from unit handshake to cdb_valid, one broadcast per cycle sustained.
// Backpressure: cdb_valid && !cdb_ready stalls everything; all unit_ready drop to zero.
module cdb_arbiter
    import ppc_types::*;
#(
    parameter int NUM_UNITS   = NUM_EXEC_UNITS,
    parameter int RS_ID_WIDTH = RS_ID_W,
    parameter int DATA_WIDTH  = DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_UNITS-1:0]          unit_valid,
    output logic [NUM_UNITS-1:0]          unit_ready,
    input  cdb_result_t [NUM_UNITS-1:0]   unit_result,
    output logic                          cdb_valid,
    input  logic                          cdb_ready,
    output cdb_result_t                   cdb_result,
    output logic [$clog2(NUM_UNITS)-1:0]  cdb_grant_id
);

    localparam int GID_W = $clog2(NUM_UNITS);

    // The payload struct is fixed by the shared package; catch a mismatched override early.
    if (RS_ID_WIDTH != RS_ID_W || DATA_WIDTH != DATA_W) begin : g_width_chk
        $error("cdb_arbiter: RS_ID_WIDTH/DATA_WIDTH must match ppc_types");
    end

    logic [GID_W-1:0]     rr_ptr;
    logic [GID_W-1:0]     win_idx;
    logic [NUM_UNITS-1:0] gnt;
    logic                 can_load;
    logic                 xfer;

    assign can_load = !cdb_valid || cdb_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_UNITS),
        .IDX_W   (GID_W)
    ) u_rr (
        .req     (unit_valid),
        .ptr     (rr_ptr),
        .en      (can_load && !rst),
        .gnt     (gnt),
        .gnt_idx (win_idx)
    );

    assign unit_ready = gnt;
    // Grant is only ever raised on a valid request, so any grant bit is a transfer.
    assign xfer       = |gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid    <= 1'b0;
            cdb_result   <= '0;
            cdb_grant_id <= '0;
            rr_ptr       <= '0;
        end else if (xfer) begin
            cdb_valid    <= 1'b1;
            cdb_result   <= unit_result[win_idx];
            cdb_grant_id <= win_idx;
            rr_ptr       <= (win_idx == GID_W'(NUM_UNITS - 1)) ? '0 : win_idx + 1'b1;
        end else if (cdb_ready) begin
            cdb_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a distance-based round-robin model.
module tb_cdb_arbiter;
    import ppc_types::*;

    localparam int N = 8;

    logic                  clk;
    logic                  rst;
    logic [N-1:0]          uv;
    logic [N-1:0]          unit_ready;
    cdb_result_t [N-1:0]   ures;
    logic                  cdb_valid;
    logic                  crdy;
    cdb_result_t           cdb_result;
    logic [2:0]            cdb_grant_id;

    cdb_arbiter #(.NUM_UNITS(N), .RS_ID_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .unit_valid   (uv),
        .unit_ready   (unit_ready),
        .unit_result  (ures),
        .cdb_valid    (cdb_valid),
        .cdb_ready    (crdy),
        .cdb_result   (cdb_result),
        .cdb_grant_id (cdb_grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    logic        m_vld;
    cdb_result_t m_res;
    int          m_gid;
    int          m_ptr;

    logic [N-1:0] last_ur;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic cdb_result_t rnd_res();
        cdb_result_t r;
        r.rs_id  = 5'($urandom);
        r.result = $urandom;
        r.so     = 1'($urandom);
        r.cr_en  = 1'($urandom);
        r.cr     = 4'($urandom);
        return r;
    endfunction

    // Winner = valid unit at the smallest forward distance from the pointer.
    function automatic int pick(input logic [N-1:0] v, input int p);
        int best = -1;
        int bd   = N;
        for (int i = 0; i < N; i++) begin
            int d;
            d = (i - p + N) % N;
            if (v[i] && d < bd) begin
                bd   = d;
                best = i;
            end
        end
        return best;
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        int           w;
        logic [N-1:0] er;
        #1;
        w  = pick(uv, m_ptr);
        er = '0;
        if (!rst && (!m_vld || crdy) && w >= 0) er[w] = 1'b1;
        last_ur = unit_ready;
        check("unit_ready", 64'(unit_ready), 64'(er));
        @(posedge clk);
        if (rst) begin
            m_vld = 1'b0;
            m_res = '0;
            m_gid = 0;
            m_ptr = 0;
        end else if (er != '0) begin
            m_vld = 1'b1;
            m_res = ures[w];
            m_gid = w;
            m_ptr = (w + 1) % N;
        end else if (crdy) begin
            m_vld = 1'b0;
        end
        @(negedge clk);
        if (er != '0) uv[w] = 1'b0;
        check("cdb_valid", 64'(cdb_valid), 64'(m_vld));
        if (m_vld) begin
            check("cdb_result", 64'(cdb_result), 64'(m_res));
            check("cdb_grant_id", 64'(cdb_grant_id), 64'(m_gid));
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        uv  = '0;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    task automatic refill_all();
        for (int i = 0; i < N; i++) begin
            if (!uv[i]) begin
                uv[i]   = 1'b1;
                ures[i] = rnd_res();
            end
        end
    endtask

    initial begin
        cdb_result_t hold;
        m_vld = 1'b0;
        m_res = '0;
        m_gid = 0;
        m_ptr = 0;
        rst   = 1'b1;
        crdy  = 1'b0;
        uv    = '1;
        for (int i = 0; i < N; i++) ures[i] = rnd_res();

        // Reset with everyone requesting
        @(negedge clk);
        step();
        check("rst_ready0", 64'(last_ur), 64'(0));
        step();
        check("rst_ready1", 64'(last_ur), 64'(0));
        rst = 1'b0;
        check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        check("rst_cdb_result", 64'(cdb_result), 64'(0));
        check("rst_grant_id", 64'(cdb_grant_id), 64'(0));

        // First grant goes to unit 0, then a full gap-free wrap
        crdy = 1'b1;
        step();
        check("first_grant", 64'(last_ur), 64'(8'h01));
        for (int k = 1; k <= N; k++) begin
            refill_all();
            step();
            check("rr_seq_valid", 64'(cdb_valid), 64'(1));
            check("rr_seq_id", 64'(cdb_grant_id), 64'(k % N));
        end
        uv = '0;
        step();

        // Single requester
        do_reset(1);
        crdy    = 1'b1;
        uv      = 8'h08;
        ures[3] = '{rs_id: 5'd17, result: 32'hDEADBEEF, so: 1'b0, cr_en: 1'b1, cr: 4'h5};
        step();
        check("single_ready", 64'(last_ur), 64'(8'b0000_1000));
        check("single_rs_id", 64'(cdb_result.rs_id), 64'(17));
        check("single_result", 64'(cdb_result.result), 64'(32'hDEADBEEF));
        check("single_gid", 64'(cdb_grant_id), 64'(3));
        step();

        // Pointer skip: grant 5 moves pointer to 6, then 1 wins over 4 via the wrap
        uv      = 8'h20;
        ures[5] = rnd_res();
        step();
        uv = '0;
        step();
        uv      = 8'h12;
        ures[1] = rnd_res();
        ures[4] = rnd_res();
        step();
        check("skip_first", 64'(cdb_grant_id), 64'(1));
        step();
        check("skip_second", 64'(cdb_grant_id), 64'(4));
        uv = '0;
        step();

        // Backpressure with units 2 and 5 pending (pointer at 5)
        crdy    = 1'b0;
        uv      = 8'h24;
        ures[2] = rnd_res();
        ures[5] = rnd_res();
        step();
        hold = cdb_result;
        check("bp_load_gid", 64'(cdb_grant_id), 64'(5));
        repeat (3) begin
            step();
            check("bp_ready", 64'(last_ur), 64'(0));
            check("bp_hold", 64'(cdb_result), 64'(hold));
        end
        crdy = 1'b1;
        step();
        check("bp_release_gid", 64'(cdb_grant_id), 64'(2));
        step();
        check("bp_drained", 64'(cdb_valid), 64'(0));

        // Reset in the middle of a stall; the stalled result must vanish
        crdy    = 1'b0;
        uv      = 8'h04;
        ures[2] = rnd_res();
        step();
        check("stall_loaded", 64'(cdb_valid), 64'(1));
        do_reset(1);
        check("stall_rst_valid", 64'(cdb_valid), 64'(0));
        crdy = 1'b1;
        step();
        check("stall_never_sent", 64'(cdb_valid), 64'(0));
        uv      = 8'h81;
        ures[0] = rnd_res();
        ures[7] = rnd_res();
        step();
        check("stall_ptr_zero", 64'(cdb_grant_id), 64'(0));
        step();

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            rst  = ($urandom_range(0, 249) == 0);
            crdy = ($urandom_range(0, 3) != 0);
            if (rst) begin
                uv = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (!uv[i] && $urandom_range(0, 2) == 0) begin
                        uv[i]   = 1'b1;
                        ures[i] = rnd_res();
                    end
                end
            end
            step();
        end

        // Drain
        rst  = 1'b0;
        uv   = '0;
        crdy = 1'b1;
        repeat (2) step();
        check("final_empty", 64'(cdb_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
